// File: rtl/ha_seq_pkg.sv
// ha_seq_pkg -- shared definitions for the bit-serial adder sequencer.
//   state_e       : sequencer states (IDLE, PH_A, PH_B, DONE)
//   WIDTH_DEFAULT : default operand/sum width in bits
package ha_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ha_serial_seq_cell.sv
// ha_cell -- single half-adder cell, purely combinational.
//   a, b : input bits
//   s    : a ^ b
//   c    : a & b
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/ha_serial_seq.sv
// ha_serial_seq -- bit-serial adder, {cout,sum} = op_a + op_b + cin,
// built from one shared half-adder cell used twice per bit, LSB first.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a new addition (accepted only when ready)
//   op_a, op_b, cin   : operands, captured on the accepting edge
//   ready             : idle, can accept start
//   busy              : working through the bit phases
//   done              : one-cycle pulse, sum/cout just updated
//   sum, cout         : registered result, held until the next done
module ha_serial_seq
  import ha_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, sum_q;
  logic               s1_q, c1_q, carry_q, cout_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ready_q, busy_q, done_q;

  logic               cell_a, cell_b, cell_s, cell_c;
  logic [WIDTH-1:0]   acc_d;
  logic               carry_d;

  // PH_A feeds the operand bits, PH_B feeds the partial sum and running carry.
  always_comb begin
    cell_a = a_q[idx_q];
    cell_b = b_q[idx_q];
    if (state_q == PH_B) begin
      cell_a = s1_q;
      cell_b = carry_q;
    end
  end

  ha_cell u_cell (
    .a (cell_a),
    .b (cell_b),
    .s (cell_s),
    .c (cell_c)
  );

  // Next working sum and carry as seen at the end of PH_B; the last bit's
  // values are forwarded straight into sum/cout on DONE entry.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = cell_s;
    carry_d      = c1_q | cell_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PH_A;
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= cin;
            acc_q   <= '0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        PH_A: begin
          s1_q    <= cell_s;
          c1_q    <= cell_c;
          state_q <= PH_B;
        end
        PH_B: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= PH_A;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_ha_serial_seq.sv
// tb_ha_serial_seq -- directed and random bench for ha_serial_seq.
// Three instances (WIDTH 4, 8, 16) share clock, reset, start and operand
// buses; directed cases target the 8-bit instance, random cases all three.
module tb_ha_serial_seq;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] opa, opb;

  logic        rdy4, bsy4, dn4, co4;
  logic [3:0]  sum4;
  logic        rdy8, bsy8, dn8, co8;
  logic [7:0]  sum8;
  logic        rdy16, bsy16, dn16, co16;
  logic [15:0] sum16;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [8:0]  prev9 = '0;

  always #5 clk = ~clk;

  ha_serial_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op_a(opa[3:0]), .op_b(opb[3:0]), .cin(cin),
    .ready(rdy4), .busy(bsy4), .done(dn4), .sum(sum4), .cout(co4)
  );

  ha_serial_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .op_a(opa[7:0]), .op_b(opb[7:0]), .cin(cin),
    .ready(rdy8), .busy(bsy8), .done(dn8), .sum(sum8), .cout(co8)
  );

  ha_serial_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .op_a(opa), .op_b(opb), .cin(cin),
    .ready(rdy16), .busy(bsy16), .done(dn16), .sum(sum16), .cout(co16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns aligned #1 after a rising edge with all instances idle.
  task automatic wait_all_idle();
    for (int i = 0; i < 100; i++) begin
      if (rdy4 && rdy8 && rdy16) break;
      @(posedge clk); #1;
    end
    check_eq("all_idle", 32'({rdy4, rdy8, rdy16}), 32'h7);
  endtask

  // One-cycle start pulse; operands are scrambled right after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c);
    opa = a; opb = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = 16'($urandom); opb = 16'($urandom); cin = 1'($urandom);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [8:0] exp);
    int lat;
    lat = 0;
    wait_all_idle();
    launch({8'h00, a}, {8'h00, b}, c);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) check_eq({tag, "_hold"}, 32'({co8, sum8}), 32'(prev9));
      if (dn8) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd17);
    check_eq({tag, "_res"}, 32'({co8, sum8}), 32'(exp));
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'({dn8, rdy8}), 32'h1);
    prev9 = exp;
    @(posedge clk); #1;
  endtask

  initial begin
    int ndone, first, rcnt, dcnt;
    int dc[3];
    int rp[2];
    logic [15:0] ra, rb;
    logic        rc;
    logic        seen4, seen8, seen16;
    logic [4:0]  got4;
    logic [8:0]  got8;
    logic [16:0] got16;

    rst = 1'b1; start = 1'b0; cin = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_flags", 32'({rdy8, bsy8, dn8}), 32'h4);
    check_eq("rst_res8", 32'({co8, sum8}), 32'h0);
    check_eq("rst_res16", 32'({co16, sum16}), 32'h0);
    @(posedge clk); #1;

    run8("ripple",   8'hFF, 8'h01, 1'b0, 9'h100);
    run8("cin_only", 8'h00, 8'h00, 1'b1, 9'h001);
    run8("all_ones", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    run8("alt",      8'hA5, 8'h5A, 1'b0, 9'h0FF);
    run8("msb",      8'h80, 8'h80, 1'b0, 9'h100);

    // start while busy must be ignored and not queued
    wait_all_idle();
    launch(16'h0012, 16'h0034, 1'b0);
    ndone = 0; first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dn8) begin
        ndone++;
        if (first == 0) first = n;
      end
      @(posedge clk); #1;
      if (n + 1 == 5) begin
        start = 1'b1; opa = 16'h00AA; opb = 16'h0055;
      end else begin
        start = 1'b0;
      end
    end
    check_eq("ign_lat", 32'(first), 32'd17);
    check_eq("ign_count", 32'(ndone), 32'd1);
    check_eq("ign_res", 32'({co8, sum8}), 32'h046);
    prev9 = 9'h046;

    // reset mid-operation aborts without a done pulse
    wait_all_idle();
    launch(16'h000F, 16'h0001, 1'b0);
    ndone = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (dn8) ndone++;
      @(posedge clk); #1;
      rst = (n + 1 == 6);
    end
    @(negedge clk);
    check_eq("rmid_flags", 32'({rdy8, bsy8, dn8}), 32'h4);
    check_eq("rmid_res", 32'({co8, sum8}), 32'h0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (dn8) ndone++;
    end
    check_eq("rmid_nodone", 32'(ndone), 32'd0);
    prev9 = '0;
    @(posedge clk); #1;

    // start held high: one result every 18 cycles, ready for one cycle between
    wait_all_idle();
    opa = 16'h003C; opb = 16'h000F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dcnt = 0; rcnt = 0;
    dc = '{0, 0, 0}; rp = '{0, 0};
    for (int n = 1; n <= 53; n++) begin
      @(negedge clk);
      if (dn8) begin
        if (dcnt < 3) dc[dcnt] = n;
        dcnt++;
      end
      if (rdy8) begin
        if (rcnt < 2) rp[rcnt] = n;
        rcnt++;
      end
    end
    check_eq("b2b_done0", 32'(dc[0]), 32'd17);
    check_eq("b2b_done1", 32'(dc[1]), 32'd35);
    check_eq("b2b_done2", 32'(dc[2]), 32'd53);
    check_eq("b2b_ndone", 32'(dcnt), 32'd3);
    check_eq("b2b_nready", 32'(rcnt), 32'd2);
    check_eq("b2b_ready0", 32'(rp[0]), 32'd18);
    check_eq("b2b_ready1", 32'(rp[1]), 32'd36);
    check_eq("b2b_res", 32'({co8, sum8}), 32'h04B);
    @(posedge clk); #1;
    start = 1'b0;

    // random operations on all three widths
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      wait_all_idle();
      launch(ra, rb, rc);
      seen4 = 1'b0; seen8 = 1'b0; seen16 = 1'b0;
      got4 = '0; got8 = '0; got16 = '0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (dn4 && !seen4) begin seen4 = 1'b1; got4 = {co4, sum4}; end
        if (dn8 && !seen8) begin seen8 = 1'b1; got8 = {co8, sum8}; end
        if (dn16 && !seen16) begin seen16 = 1'b1; got16 = {co16, sum16}; end
        if (seen4 && seen8 && seen16) break;
      end
      check_eq("rnd_seen", 32'({seen4, seen8, seen16}), 32'h7);
      check_eq("rnd_w4", 32'(got4), 32'(5'(ra[3:0]) + 5'(rb[3:0]) + 5'(rc)));
      check_eq("rnd_w8", 32'(got8), 32'(9'(ra[7:0]) + 9'(rb[7:0]) + 9'(rc)));
      check_eq("rnd_w16", 32'(got16), 32'(17'(ra) + 17'(rb) + 17'(rc)));
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ha_serial_seq.md
HA_SERIAL_SEQ -- requirements
Module: ha_serial_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new addition; accepted only when ready=1.
REQ-005 op_a  input  WIDTH  addend A; sampled on the accepting edge.
REQ-006 op_b  input  WIDTH  addend B; sampled on the accepting edge.
REQ-007 cin  input  1  carry-in; sampled on the accepting edge.
REQ-008 ready  output  1  high only in IDLE; block can accept start.
REQ-009 busy  output  1  high in PH_A or PH_B.
REQ-010 done  output  1  one-cycle pulse; sum/cout are valid and newly updated.
REQ-011 sum  output  WIDTH  registered result; held until the next done.
REQ-012 cout  output  1  registered carry-out; held until the next done.

Function
REQ-013 The block SHALL compute {cout,sum} = op_a + op_b + cin with one shared half-adder cell, one full-add bit per two cycles, LSB first.
REQ-014 States SHALL be IDLE, PH_A, PH_B and DONE.
REQ-015 IDLE SHALL go to PH_A on start=1, capture op_a, op_b and cin, and clear the bit index to 0; otherwise it SHALL stay in IDLE.
REQ-016 PH_A SHALL drive the cell with (a[i], b[i]), register s1 = a[i]^b[i] and c1 = a[i]&b[i], then go to PH_B.
REQ-017 PH_B SHALL drive the cell with (s1, carry), write s1^carry into sum bit i and set carry = c1 | (s1&carry).
REQ-018 PH_B SHALL go to PH_A with i+1 if i<WIDTH-1, and to DONE if i=WIDTH-1.
REQ-019 On entry to DONE, sum and cout SHALL load the accumulated result; done=1 for exactly that cycle; next state IDLE.
REQ-020 Latency: done SHALL assert 2*WIDTH+1 cycles after the accepting edge (17 for WIDTH=8).
REQ-021 start while ready=0 (PH_A, PH_B, DONE) SHALL be ignored and not queued.
REQ-022 A start held continuously SHALL be accepted again in the IDLE cycle after DONE, giving one result every 2*WIDTH+2 cycles.
REQ-023 Changes on op_a, op_b or cin after the accepting edge SHALL NOT affect the running operation.
REQ-024 The internal carry SHALL be initialised to the captured cin on acceptance; the bit index SHALL never exceed WIDTH-1.
REQ-025 sum and cout SHALL hold the previous result throughout an operation; only DONE entry updates them.

Reset
REQ-026 When rst=1 at a rising edge, the state SHALL become IDLE, with ready=1, busy=0, done=0, sum=0, cout=0, and the internal operands, s1, c1, carry and index cleared to 0.
REQ-027 rst SHALL take priority over start; reset mid-operation SHALL abort the operation with no done pulse, and sum SHALL read 0 afterwards.

Structure
REQ-028 Package ha_seq_pkg SHALL hold the state enum (IDLE, PH_A, PH_B, DONE) and the WIDTH default constant.
REQ-029 Sub-module ha_cell (purely combinational, a,b -> s,c) SHALL be instantiated exactly once; all additions SHALL go through it.
REQ-030 Datapath registers SHALL be: captured A, captured B, working sum shift/bit register, s1, c1, carry, index, sum_q, cout_q.

Verification
REQ-031 Carry ripple: op_a=8'hFF, op_b=8'h01, cin=0, start for one cycle -> done at cycle 17, sum=8'h00, cout=1.
REQ-032 Carry-in only: op_a=8'h00, op_b=8'h00, cin=1 -> sum=8'h01, cout=0; then op_a=8'hFF, op_b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-033 Ignored start: start with 8'h12+8'h34, then start=1 with 8'hAA+8'h55 at cycle 5 -> single done at cycle 17, sum=8'h46; no second done.
REQ-034 Reset mid-op: start 8'h0F+8'h01, rst=1 at cycle 6 -> no done, ready=1 the next cycle, sum=0, cout=0.
REQ-035 Back-to-back: start held high with operands stable -> done pulses every 18 cycles, with ready=1 for exactly one cycle between operations.
REQ-036 Random: 1000 random (op_a, op_b, cin) operations checked against a reference {cout,sum}, including the WIDTH=4 and WIDTH=16 builds.
